// File: rtl/mips_dmem_ctrl.sv
// Data-memory controller for the MIPS core: valid/ready request port,
// programmable wait states, byte/half/word lanes with alignment checks,
// and a memory-mapped test register driving test_value.
module mips_dmem_ctrl #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned DEPTH       = 256,
   parameter int unsigned WAIT_STATES = 2,
   parameter logic [31:0] TEST_ADDR   = 32'h400,
   parameter int unsigned TEST_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic [31:0]       req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic [TEST_W-1:0] test_value
);

   localparam int unsigned IDX_W     = $clog2(DEPTH);
   localparam logic [31:0] MEM_BYTES = 32'(DEPTH * 4);
   localparam logic [3:0]  WAIT_CNT  = 4'(WAIT_STATES);
   localparam bit          NO_WAIT   = (WAIT_STATES == 0);

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [31:0]       addr_q;
   logic              we_q;
   logic [1:0]        size_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              go_resp;
   logic [31:0]       op_addr;
   logic              op_we;
   logic [1:0]        op_size;
   logic [DATA_W-1:0] op_wdata;
   logic [IDX_W-1:0]  op_idx;
   logic              op_err;
   logic              is_test;
   logic [4:0]        lane_sh;
   logic [DATA_W-1:0] base_mask, word_rd, ld_data, wr_word;

   assign req_ready = (state_q == StIdle);
   assign rsp_valid = (state_q == StResp);

   // Operands come straight from the request in IDLE (zero-wait commit) and from
   // the captured copy otherwise; errors never reach WAIT so only IDLE sees them.
   always_comb begin
      op_addr  = (state_q == StIdle) ? req_addr  : addr_q;
      op_we    = (state_q == StIdle) ? req_we    : we_q;
      op_size  = (state_q == StIdle) ? req_size  : size_q;
      op_wdata = (state_q == StIdle) ? req_wdata : wdata_q;
      op_idx   = op_addr[IDX_W+1:2];
      is_test  = (op_addr == TEST_ADDR);
      op_err   = 1'b0;
      case (op_size)
         2'b00:   op_err = 1'b0;
         2'b01:   op_err = op_addr[0];
         2'b10:   op_err = (op_addr[1:0] != 2'b00);
         default: op_err = 1'b1;
      endcase
      if (op_addr >= MEM_BYTES && !is_test) op_err = 1'b1;
      if (is_test && op_size != 2'b10) op_err = 1'b1;
   end

   // Lane extraction for loads and read-modify-write merge for stores.
   always_comb begin
      lane_sh   = 5'd0;
      base_mask = '1;
      case (op_size)
         2'b00: begin
            lane_sh   = {op_addr[1:0], 3'b000};
            base_mask = DATA_W'(8'hFF);
         end
         2'b01: begin
            lane_sh   = {op_addr[1], 4'b0000};
            base_mask = DATA_W'(16'hFFFF);
         end
         default: begin
            lane_sh   = 5'd0;
            base_mask = '1;
         end
      endcase
      word_rd = mem[op_idx];
      ld_data = is_test ? DATA_W'(test_value) : ((word_rd >> lane_sh) & base_mask);
      wr_word = (word_rd & ~(base_mask << lane_sh)) |
                ((op_wdata & base_mask) << lane_sh);
   end

   // Next-state logic; go_resp marks the edge that enters RESP (commit edge).
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      go_resp = 1'b0;
      case (state_q)
         StIdle: begin
            if (req_valid) begin
               cnt_d = WAIT_CNT;
               if (op_err || NO_WAIT) begin
                  state_d = StResp;
                  go_resp = 1'b1;
               end else begin
                  state_d = StWait;
               end
            end
         end
         StWait: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = StResp;
               go_resp = 1'b1;
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // FSM state, wait counter and request capture.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         addr_q  <= '0;
         we_q    <= 1'b0;
         size_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (state_q == StIdle && req_valid) begin
            addr_q  <= req_addr;
            we_q    <= req_we;
            size_q  <= req_size;
            wdata_q <= req_wdata;
         end
      end
   end

   // Memory, test register and response registers update on the commit edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
         test_value <= '0;
         rsp_rdata  <= '0;
         rsp_err    <= 1'b0;
      end else if (go_resp) begin
         rsp_err   <= op_err;
         rsp_rdata <= (op_err || op_we) ? '0 : ld_data;
         if (!op_err && op_we) begin
            if (is_test) test_value <= op_wdata[TEST_W-1:0];
            else         mem[op_idx] <= wr_word;
         end
      end
   end

endmodule

// File: tb/tb_mips_dmem_ctrl.sv
// Self-checking bench: directed vector table on a 2-wait-state instance plus
// hand sequences for held output data, reset abort and zero-wait streaming.
module tb_mips_dmem_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;

   // Instance with WAIT_STATES=2
   logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
   logic [1:0]  req_size = 2'b10;
   logic [31:0] req_addr = '0, req_wdata = '0, rsp_rdata;
   logic        rsp_valid, rsp_err;
   logic [15:0] test_value;

   // Instance with WAIT_STATES=0
   logic        v0 = 1'b0, rdy0, we0 = 1'b0, rv0, er0;
   logic [1:0]  sz0 = 2'b10;
   logic [31:0] a0 = '0, wd0 = '0, rd0;
   logic [15:0] tv0;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   mips_dmem_ctrl #(.WAIT_STATES(2)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_size(req_size), .req_addr(req_addr),
      .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .test_value(test_value)
   );

   mips_dmem_ctrl #(.WAIT_STATES(0)) dut0 (
      .clk(clk), .rst(rst), .req_valid(v0), .req_ready(rdy0),
      .req_we(we0), .req_size(sz0), .req_addr(a0),
      .req_wdata(wd0), .rsp_valid(rv0), .rsp_rdata(rd0),
      .rsp_err(er0), .test_value(tv0)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   // One request on the 2-wait instance; lat counts negedges from accept to rsp_valid.
   task automatic txn(input logic we, input logic [1:0] size, input logic [31:0] addr,
                      input logic [31:0] wdata, output logic [31:0] rd,
                      output logic er, output int lat);
      int n;
      @(negedge clk);
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      req_valid = 1'b1;
      req_we    = we;
      req_size  = size;
      req_addr  = addr;
      req_wdata = wdata;
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0;
      rd  = '0;
      er  = 1'b0;
      while (lat < 40) begin
         @(negedge clk);
         lat++;
         if (rsp_valid) break;
      end
      rd = rsp_rdata;
      er = rsp_err;
   endtask

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        chk_rd;
      logic        exp_err;
      int          exp_lat;
      logic [15:0] exp_tv;
   } vec_t;

   localparam int NV = 24;
   vec_t vecs[NV];

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat;

      //           we    size   addr      wdata         exp_rd     chk  err  lat tv
      vecs[0]  = '{1'b1, 2'b10, 32'h010, 32'hDEADBEEF, 32'h0,       1'b0, 1'b0, 3, 16'h0};
      vecs[1]  = '{1'b0, 2'b10, 32'h010, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0, 3, 16'h0};
      vecs[2]  = '{1'b1, 2'b00, 32'h021, 32'h000000AA, 32'h0,       1'b0, 1'b0, 3, 16'h0};
      vecs[3]  = '{1'b0, 2'b10, 32'h020, 32'h0,        32'h0000AA00, 1'b1, 1'b0, 3, 16'h0};
      vecs[4]  = '{1'b0, 2'b00, 32'h021, 32'h0,        32'h000000AA, 1'b1, 1'b0, 3, 16'h0};
      vecs[5]  = '{1'b0, 2'b01, 32'h013, 32'h0,        32'h0,       1'b1, 1'b1, 1, 16'h0};
      vecs[6]  = '{1'b1, 2'b10, 32'h3FE, 32'h11111111, 32'h0,       1'b1, 1'b1, 1, 16'h0};
      vecs[7]  = '{1'b0, 2'b11, 32'h010, 32'h0,        32'h0,       1'b1, 1'b1, 1, 16'h0};
      vecs[8]  = '{1'b0, 2'b10, 32'h010, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0, 3, 16'h0};
      vecs[9]  = '{1'b1, 2'b10, 32'h400, 32'h12345678, 32'h0,       1'b0, 1'b0, 3, 16'h5678};
      vecs[10] = '{1'b1, 2'b01, 32'h400, 32'h0000FFFF, 32'h0,       1'b1, 1'b1, 1, 16'h5678};
      vecs[11] = '{1'b0, 2'b10, 32'h400, 32'h0,        32'h00005678, 1'b1, 1'b0, 3, 16'h5678};
      vecs[12] = '{1'b1, 2'b01, 32'h012, 32'h0000CAFE, 32'h0,       1'b0, 1'b0, 3, 16'h5678};
      vecs[13] = '{1'b0, 2'b10, 32'h010, 32'h0,        32'hCAFEBEEF, 1'b1, 1'b0, 3, 16'h5678};
      vecs[14] = '{1'b0, 2'b01, 32'h012, 32'h0,        32'h0000CAFE, 1'b1, 1'b0, 3, 16'h5678};
      vecs[15] = '{1'b0, 2'b00, 32'h013, 32'h0,        32'h000000CA, 1'b1, 1'b0, 3, 16'h5678};
      vecs[16] = '{1'b0, 2'b00, 32'h010, 32'h0,        32'h000000EF, 1'b1, 1'b0, 3, 16'h5678};
      vecs[17] = '{1'b0, 2'b10, 32'h3FC, 32'h0,        32'h0,       1'b1, 1'b0, 3, 16'h5678};
      vecs[18] = '{1'b0, 2'b10, 32'h404, 32'h0,        32'h0,       1'b1, 1'b1, 1, 16'h5678};
      vecs[19] = '{1'b1, 2'b00, 32'h3FF, 32'h1234565A, 32'h0,       1'b0, 1'b0, 3, 16'h5678};
      vecs[20] = '{1'b0, 2'b10, 32'h3FC, 32'h0,        32'h5A000000, 1'b1, 1'b0, 3, 16'h5678};
      vecs[21] = '{1'b0, 2'b00, 32'h400, 32'h0,        32'h0,       1'b1, 1'b1, 1, 16'h5678};
      vecs[22] = '{1'b0, 2'b01, 32'h011, 32'h0,        32'h0,       1'b1, 1'b1, 1, 16'h5678};
      vecs[23] = '{1'b0, 2'b10, 32'h022, 32'h0,        32'h0,       1'b1, 1'b1, 1, 16'h5678};

      // Reset state
      repeat (3) @(negedge clk);
      chk("reset req_ready", 32'(req_ready), 32'd1);
      chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset rsp_rdata", rsp_rdata, 32'h0);
      chk("reset rsp_err", 32'(rsp_err), 32'd0);
      chk("reset test_value", 32'(test_value), 32'h0);
      rst = 1'b1;

      // Directed vector table
      for (int i = 0; i < NV; i++) begin
         txn(vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata, rd, er, lat);
         chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
         chk($sformatf("vec%0d rsp_err", i), 32'(er), 32'(vecs[i].exp_err));
         if (vecs[i].chk_rd) chk($sformatf("vec%0d rsp_rdata", i), rd, vecs[i].exp_rd);
         chk($sformatf("vec%0d test_value", i), 32'(test_value), 32'(vecs[i].exp_tv));
      end

      // Response data holds after rsp_valid falls
      txn(1'b0, 2'b10, 32'h010, 32'h0, rd, er, lat);
      chk("hold load rdata", rd, 32'hCAFEBEEF);
      repeat (2) @(negedge clk);
      chk("hold rsp_valid low", 32'(rsp_valid), 32'd0);
      chk("hold rsp_rdata", rsp_rdata, 32'hCAFEBEEF);
      chk("hold rsp_err", 32'(rsp_err), 32'd0);

      // Reset during WAIT of a store aborts it
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_size  = 2'b10;
      req_addr  = 32'h040;
      req_wdata = 32'h00000077;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("abort in wait", 32'(req_ready), 32'd0);
      rst = 1'b0;
      #1;
      chk("abort async ready", 32'(req_ready), 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("abort rsp_valid in reset %0d", i), 32'(rsp_valid), 32'd0);
      end
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("abort rsp_valid after %0d", i), 32'(rsp_valid), 32'd0);
         chk($sformatf("abort req_ready after %0d", i), 32'(req_ready), 32'd1);
      end
      chk("abort test_value cleared", 32'(test_value), 32'h0);
      txn(1'b0, 2'b10, 32'h040, 32'h0, rd, er, lat);
      chk("abort target word", rd, 32'h0);
      chk("abort reload latency", 32'(lat), 32'd3);

      // Zero-wait instance with req_valid held high: store, then loads back
      @(negedge clk);
      v0  = 1'b1;
      we0 = 1'b1;
      sz0 = 2'b10;
      a0  = 32'h008;
      wd0 = 32'hA5A5A5A5;
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("stream%0d req_ready", i), 32'(rdy0), 32'((i % 2) == 0));
         chk($sformatf("stream%0d rsp_valid", i), 32'(rv0), 32'((i % 2) == 1));
         if (i == 1) begin
            we0 = 1'b0;
         end
         if (i >= 3 && (i % 2) == 1) begin
            chk($sformatf("stream%0d rdata", i), rd0, 32'hA5A5A5A5);
            chk($sformatf("stream%0d err", i), 32'(er0), 32'd0);
         end
         @(negedge clk);
      end
      v0 = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "timeout");
   end

endmodule
